// File: rtl/alu_control_mdu.sv
// ALU control decode plus an iterative multiply/divide unit with HI/LO result registers.
// Define ALU_CONTROL_MDU_DIV_EN to build the restoring divider (div/divu); otherwise only mult/multu.
module alu_control_mdu #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic              issue,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [CTRL_W-1:0] alu_control,
  output logic              illegal,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int W  = DATA_W;
  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  w_q, w_d;
  logic [W-1:0]    mb_q, mb_d;
  logic            neg_q, neg_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;

  logic [3:0]      ctrl4;
  logic            is_mul, is_div, is_mf, sgn, accept;
  logic [W-1:0]    mag_rs, mag_rt, fin_hi, fin_lo;
  logic [W:0]      msum;
  logic [2*W-1:0]  mstep, mprod, step;

  always_comb begin
    ctrl4   = 4'b0000;
    illegal = 1'b0;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mf   = 1'b0;
    sgn     = 1'b0;
    case (alu_op)
      2'b00: ctrl4 = 4'b0010;
      2'b01: ctrl4 = 4'b0111;
      2'b10: begin
        case (funct)
          6'b100000: ctrl4 = 4'b0010;
          6'b100010: ctrl4 = 4'b0110;
          6'b100100: ctrl4 = 4'b0000;
          6'b100101: ctrl4 = 4'b0001;
          6'b100110: ctrl4 = 4'b0011;
          6'b101010: ctrl4 = 4'b0111;
          6'b011000: begin is_mul = 1'b1; sgn = 1'b1; end
          6'b011001: is_mul = 1'b1;
`ifdef ALU_CONTROL_MDU_DIV_EN
          6'b011010: begin is_div = 1'b1; sgn = 1'b1; end
          6'b011011: is_div = 1'b1;
`endif
          6'b010000, 6'b010010: is_mf = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      2'b11: begin
        case (funct)
          6'b100100: ctrl4 = 4'b0000;
          6'b100101: ctrl4 = 4'b0001;
          6'b100110: ctrl4 = 4'b0011;
          default:   illegal = 1'b1;
        endcase
      end
    endcase
  end

  assign alu_control = CTRL_W'(ctrl4);
  assign stall  = issue && (state_q == RUN) && (is_mul || is_div || is_mf);
  assign accept = issue && (state_q != RUN) && (is_mul || is_div);
  assign mag_rs = (sgn && rs_val[W-1]) ? -rs_val : rs_val;
  assign mag_rt = (sgn && rt_val[W-1]) ? -rt_val : rt_val;

  // Shift-add: upper half accumulates, lower half shifts the multiplier out LSB first.
  always_comb begin
    msum  = {1'b0, w_q[2*W-1:W]} + ({1'b0, mb_q} & {(W+1){w_q[0]}});
    mstep = {msum, w_q[W-1:1]};
    mprod = neg_q ? -mstep : mstep;
  end

`ifdef ALU_CONTROL_MDU_DIV_EN
  logic         div_q, div_d, rneg_q, rneg_d;
  logic [W-1:0] a_q, a_d, dq, dr;
  logic [W:0]   rp, diff;
  logic [2*W-1:0] dstep;

  // Restoring step: remainder in the upper half, dividend shifts out / quotient shifts in below.
  always_comb begin
    rp     = {w_q[2*W-1:W], w_q[W-1]};
    diff   = rp - {1'b0, mb_q};
    dstep  = {diff[W] ? rp[W-1:0] : diff[W-1:0], w_q[W-2:0], ~diff[W]};
    dq     = dstep[W-1:0];
    dr     = dstep[2*W-1:W];
    step   = div_q ? dstep : mstep;
    if (!div_q) begin
      fin_hi = mprod[2*W-1:W];
      fin_lo = mprod[W-1:0];
    end else if (mb_q == '0) begin
      fin_hi = a_q;
      fin_lo = '1;
    end else begin
      fin_hi = rneg_q ? -dr : dr;
      fin_lo = neg_q  ? -dq : dq;
    end
  end
`else
  always_comb begin
    step   = mstep;
    fin_hi = mprod[2*W-1:W];
    fin_lo = mprod[W-1:0];
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    mb_d    = mb_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef ALU_CONTROL_MDU_DIV_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
    a_d     = a_q;
`endif
    case (state_q)
      RUN: begin
        w_d = step;
        if (cnt_q == CW'(W-1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = fin_hi;
          lo_d    = fin_lo;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          neg_d   = sgn && (rs_val[W-1] ^ rt_val[W-1]);
          w_d     = {{W{1'b0}}, is_div ? mag_rs : mag_rt};
          mb_d    = is_div ? mag_rt : mag_rs;
`ifdef ALU_CONTROL_MDU_DIV_EN
          div_d   = is_div;
          rneg_d  = sgn && rs_val[W-1];
          a_d     = rs_val;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      mb_q    <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef ALU_CONTROL_MDU_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
      a_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      mb_q    <= mb_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef ALU_CONTROL_MDU_DIV_EN
      div_q   <= div_d;
      rneg_q  <= rneg_d;
      a_q     <= a_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_alu_control_mdu.sv
// Bench for alu_control_mdu (DATA_W=32): directed corners plus random ops vs an arithmetic model.
module tb_alu_control_mdu;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010,
                         F_DIVU = 6'b011011, F_MFLO = 6'b010010;
`ifdef ALU_CONTROL_MDU_DIV_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, issue = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  funct = 6'b0;
  logic [31:0] rs_val = '0, rt_val = '0, hi, lo;
  logic [3:0]  alu_control;
  logic        illegal, stall, busy, done;
  int          total = 0, bad = 0;
  logic [63:0] last_res = '0;

  alu_control_mdu #(.DATA_W(32), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct(funct), .issue(issue),
    .rs_val(rs_val), .rt_val(rt_val), .alu_control(alu_control), .illegal(illegal),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {illegal, alu_control} from the op-class / funct rules
  function automatic logic [4:0] dec_model(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 5'b0_0010;
    if (op == 2'b01) return 5'b0_0111;
    if (f == 6'b100100) return 5'b0_0000;
    if (f == 6'b100101) return 5'b0_0001;
    if (f == 6'b100110) return 5'b0_0011;
    if (op == 2'b11) return 5'b1_0000;
    if (f == 6'b100000) return 5'b0_0010;
    if (f == 6'b100010) return 5'b0_0110;
    if (f == 6'b101010) return 5'b0_0111;
    if (f == F_MULT || f == F_MULTU || f == 6'b010000 || f == F_MFLO) return 5'b0_0000;
    if (DIV && (f == F_DIV || f == F_DIVU)) return 5'b0_0000;
    return 5'b1_0000;
  endfunction

  // {hi, lo} result by plain arithmetic
  function automatic logic [63:0] op_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'b0, a}; ub = {32'b0, b};
    if (f == F_MULT) return sa * sb;
    if (f == F_MULTU) return ua * ub;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (f == F_DIV) begin
      q = sa / sb; r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = ua / ub; ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  task automatic issue_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    alu_op = 2'b10; funct = f; rs_val = a; rt_val = b; issue = 1'b1;
    @(posedge clk); #1;
    issue = 1'b0; alu_op = 2'b00; funct = 6'b0;
  endtask

  // Called right after the accepting edge; returns at the negedge of the done cycle.
  task automatic wait_done(input string tag, input logic [63:0] exp, input bit poke);
    int lat = 41, busyc = 0, stall_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) chk({tag, "_hold"}, {hi, lo}, last_res);
      if (done) begin lat = k; break; end
      if (busy) busyc++;
      if (poke && k >= 4 && !stall) stall_bad++;
      if (poke && k >= 3) begin
        alu_op = 2'b10; issue = 1'b1;
        funct  = (k < 30 && k[0]) ? F_MULT : F_MFLO;
        rs_val = $urandom; rt_val = $urandom;
      end
    end
    chk({tag, "_lat"}, lat, 33);
    chk({tag, "_busy"}, busyc, 32);
    chk({tag, "_res"}, {hi, lo}, exp);
    if (poke) begin
      chk({tag, "_stall_run"}, stall_bad, 0);
      chk({tag, "_stall_done"}, stall, 0);
      issue = 1'b0; alu_op = 2'b00; funct = 6'b0;
    end
    last_res = exp;
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    chk({tag, "_pulse"}, {busy, done}, 2'b00);
    chk({tag, "_keep"}, {hi, lo}, last_res);
  endtask

  task automatic run(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    e = op_model(f, a, b);
    issue_op(f, a, b);
    wait_done(tag, e, 1'b0);
    after_done(tag);
  endtask

  initial begin
    logic [5:0] fl [6];
    logic [63:0] e;
    int ndone;
    fl[0] = F_MULT; fl[1] = F_MULTU; fl[2] = F_DIV; fl[3] = F_DIVU; fl[4] = 6'b100101; fl[5] = 6'b100000;

    repeat (3) @(negedge clk);
    chk("rst_state", {busy, done, stall, hi, lo}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    alu_op = 2'b10; funct = 6'b100010; #1;
    chk("dec_sub", {illegal, alu_control}, 5'b0_0110);
    funct = 6'b111111; #1;
    chk("dec_bad", {illegal, alu_control}, 5'b1_0000);
    for (int i = 0; i < 30; i++) begin
      alu_op = 2'($urandom);
      funct  = ($urandom_range(1, 0) == 1) ? fl[$urandom_range(5, 0)] : 6'($urandom);
      if (i % 5 == 0) funct = 6'b100100 + 6'($urandom_range(2, 0));
      #1;
      chk("dec_rand", {illegal, alu_control}, dec_model(alu_op, funct));
    end
    alu_op = 2'b00; funct = 6'b0;
    @(negedge clk);

    run("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_val", last_res, 64'hFFFF_FFFE_0000_0001);

    issue_op(F_MULT, -32'sd7, 32'sd3);
    wait_done("mult_m7x3", 64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
    after_done("mult_m7x3");

    if (DIV) begin
      run("div_m7_2", F_DIV, -32'sd7, 32'sd2);
      chk("div_m7_2_val", last_res, 64'hFFFF_FFFF_FFFF_FFFD);
      run("divu_10_0", F_DIVU, 32'd10, 32'd0);
      chk("divu_10_0_val", last_res, 64'h0000_000A_FFFF_FFFF);
      run("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_ovf_val", last_res, 64'h0000_0000_8000_0000);
    end else begin
      ndone = 0;
      alu_op = 2'b10; funct = F_DIVU; rs_val = 32'd10; rt_val = 32'd0; issue = 1'b1; #1;
      chk("divu_off_illegal", illegal, 1'b1);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (busy || done || stall) ndone++;
      end
      chk("divu_off_idle", ndone, 0);
      issue = 1'b0; alu_op = 2'b00; funct = 6'b0;
    end

    // back-to-back: new op accepted in the DONE cycle
    e = op_model(F_MULT, 32'h1234_5678, 32'h8765_4321);
    issue_op(F_MULT, 32'h1234_5678, 32'h8765_4321);
    wait_done("chain_a", e, 1'b0);
    alu_op = 2'b10; funct = F_MULTU; rs_val = 32'hDEAD_BEEF; rt_val = 32'h0000_1001; issue = 1'b1; #1;
    chk("chain_nostall", stall, 1'b0);
    @(posedge clk); #1;
    issue = 1'b0; alu_op = 2'b00; funct = 6'b0;
    wait_done("chain_b", op_model(F_MULTU, 32'hDEAD_BEEF, 32'h0000_1001), 1'b0);
    after_done("chain_b");

    for (int i = 0; i < 10; i++) begin
      logic [5:0]  f;
      logic [31:0] a, b;
      f = fl[DIV ? $urandom_range(3, 0) : $urandom_range(1, 0)];
      a = $urandom; b = $urandom;
      if (i % 4 == 1) b = 32'($urandom_range(9, 0));
      if (i % 4 == 2) a = -a;
      run("rand_op", f, a, b);
    end

    // asynchronous reset in the middle of a run
    issue_op(F_MULTU, $urandom, $urandom);
    repeat (10) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("midrst_clear", {busy, done, hi, lo}, '0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    run("post_rst_6x7", F_MULTU, 32'd6, 32'd7);
    chk("post_rst_lo", last_res[31:0], 32'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
